// File: rtl/stream_rr_arbiter.sv
// stream_rr_arbiter: round-robin N:1 valid/ready stream arbiter with a registered output.
// Optional burst lock (grant held until s_last) when STREAM_ARB_LOCK_EN is defined.
module stream_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = 2,
    parameter int DATA_W  = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        s_valid,
    output logic [NUM_REQ-1:0]        s_ready,
    input  logic [NUM_REQ*DATA_W-1:0] s_data,
    input  logic [NUM_REQ-1:0]        s_last,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATA_W-1:0]         m_data,
    output logic [IDX_W-1:0]          m_id,
    output logic                      m_last,
    output logic                      busy
);

    logic              m_valid_q, m_valid_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [IDX_W-1:0]  m_id_q, m_id_d;
    logic              m_last_q, m_last_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic [IDX_W-1:0]  rr_idx;
    logic              rr_vld;
    logic [IDX_W-1:0]  win_idx;
    logic              win_vld;
    logic [DATA_W-1:0] win_data;
    logic              win_last;
    logic              slot_free;
    logic              accept;
    logic              locked;

`ifdef STREAM_ARB_LOCK_EN
    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] lock_id_q, lock_id_d;

    assign locked = (state_q == LOCK);
`else
    assign locked = 1'b0;
`endif

    assign slot_free = !m_valid_q || m_ready;

    // First valid requester at or after ptr, wrapping around
    always_comb begin : p_search
        int k;
        rr_idx = '0;
        rr_vld = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            k = int'(ptr_q) + i;
            if (k >= NUM_REQ) begin
                k = k - NUM_REQ;
            end
            if (!rr_vld && s_valid[k]) begin
                rr_vld = 1'b1;
                rr_idx = IDX_W'(k);
            end
        end
    end

    // Winner: round-robin pick, or the locked owner while a burst is open
    always_comb begin
`ifdef STREAM_ARB_LOCK_EN
        if (locked) begin
            win_idx = lock_id_q;
            win_vld = s_valid[lock_id_q];
        end else begin
            win_idx = rr_idx;
            win_vld = rr_vld;
        end
`else
        win_idx = rr_idx;
        win_vld = rr_vld;
`endif
    end

    assign accept = rst_n && slot_free && win_vld;

    // Select winner payload and drive the one-hot ready
    always_comb begin
        win_data = '0;
        win_last = 1'b0;
        s_ready  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (win_idx == IDX_W'(k)) begin
                win_data   = s_data[k*DATA_W +: DATA_W];
                win_last   = s_last[k];
                s_ready[k] = accept;
            end
        end
    end

    // Output register and pointer next-state
    always_comb begin
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        m_id_d    = m_id_q;
        m_last_d  = m_last_q;
        ptr_d     = ptr_q;
        if (accept) begin
            m_valid_d = 1'b1;
            m_data_d  = win_data;
            m_id_d    = win_idx;
            m_last_d  = win_last;
            if (win_idx == IDX_W'(NUM_REQ - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = win_idx + IDX_W'(1);
            end
        end else if (m_ready) begin
            m_valid_d = 1'b0;
        end
    end

    // Output beat and round-robin pointer state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_id_q    <= '0;
            m_last_q  <= 1'b0;
            ptr_q     <= '0;
        end else begin
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
            m_id_q    <= m_id_d;
            m_last_q  <= m_last_d;
            ptr_q     <= ptr_d;
        end
    end

`ifdef STREAM_ARB_LOCK_EN
    // Burst lock next-state: open on a non-last beat, close on the owner's last beat
    always_comb begin
        state_d   = state_q;
        lock_id_d = lock_id_q;
        if (accept) begin
            if (state_q == ARB && !win_last) begin
                state_d   = LOCK;
                lock_id_d = win_idx;
            end else if (state_q == LOCK && win_last) begin
                state_d = ARB;
            end
        end
    end

    // Burst lock FSM state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ARB;
            lock_id_q <= '0;
        end else begin
            state_q   <= state_d;
            lock_id_q <= lock_id_d;
        end
    end
`endif

    assign m_valid = m_valid_q;
    assign m_data  = m_data_q;
    assign m_id    = m_id_q;
    assign m_last  = m_last_q;
    assign busy    = m_valid_q || locked;

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// tb_stream_rr_arbiter: table-driven grant vectors plus burst/reset sequences,
// with a scoreboard queue checking every beat leaving the output register.
module tb_stream_rr_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [127:0] s_data;
    logic [3:0]   s_last;
    logic         m_valid;
    logic         m_ready;
    logic [31:0]  m_data;
    logic [1:0]   m_id;
    logic         m_last;
    logic         busy;

    stream_rr_arbiter #(
        .NUM_REQ(4),
        .IDX_W  (2),
        .DATA_W (32)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_data (s_data),
        .s_last (s_last),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_data (m_data),
        .m_id   (m_id),
        .m_last (m_last),
        .busy   (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] sv;
        logic [3:0] sl;
        logic       mr;
        logic [3:0] rdy;
    } vec_t;

    typedef struct packed {
        logic [1:0]  id;
        logic [31:0] data;
        logic        last;
    } beat_t;

    beat_t  sbq[$];
    vec_t   tbl[15];
    logic   [7:0] cnt[4];
    logic   mv;
    int     errors = 0;
    int     checks = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] data_of(input int k);
        return 32'hA5A5_0000 | (32'(k) << 12) | 32'(cnt[k]);
    endfunction

    function automatic logic [1:0] idx_of(input logic [3:0] oh);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (oh[i]) r = 2'(i);
        end
        return r;
    endfunction

    // One clock of stimulus; inputs change #1 after the rising edge,
    // outputs are sampled on the falling edge
    task automatic do_cycle(input logic [3:0] sv, input logic [3:0] sl,
                            input logic mr, input logic [3:0] rdy);
        beat_t b;
        logic [1:0] w;
        s_valid = sv;
        s_last  = sl;
        m_ready = mr;
        for (int k = 0; k < 4; k++) begin
            s_data[k*32 +: 32] = data_of(k);
        end
        @(negedge clk);
        chk("s_ready", 32'(s_ready), 32'(rdy));
        chk("m_valid", 32'(m_valid), 32'(mv));
`ifndef STREAM_ARB_LOCK_EN
        chk("busy", 32'(busy), 32'(mv));
`endif
        if (mv) begin
            if (sbq.size() == 0) begin
                chk("scoreboard_nonempty", 32'(0), 32'(1));
            end else begin
                b = sbq[0];
                chk("m_id", 32'(m_id), 32'(b.id));
                chk("m_data", m_data, b.data);
                chk("m_last", 32'(m_last), 32'(b.last));
                if (mr) void'(sbq.pop_front());
            end
        end
        if (rdy != 4'b0000) begin
            w = idx_of(rdy);
            b.id   = w;
            b.data = data_of(int'(w));
            b.last = sl[w];
            sbq.push_back(b);
            cnt[w] = cnt[w] + 8'd1;
            mv = 1'b1;
        end else if (mr) begin
            mv = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // sv, sl, mr, expected s_ready  (starting from ptr=0, output empty)
        tbl[0]  = '{4'b0001, 4'b1111, 1'b1, 4'b0001};
        tbl[1]  = '{4'b0000, 4'b1111, 1'b1, 4'b0000};
        tbl[2]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010};
        tbl[3]  = '{4'b1111, 4'b1111, 1'b1, 4'b0100};
        tbl[4]  = '{4'b1111, 4'b1111, 1'b1, 4'b1000};
        tbl[5]  = '{4'b1111, 4'b1111, 1'b1, 4'b0001};
        tbl[6]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000};
        tbl[7]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000};
        tbl[8]  = '{4'b1111, 4'b1111, 1'b0, 4'b0000};
        tbl[9]  = '{4'b1111, 4'b1111, 1'b1, 4'b0010};
        tbl[10] = '{4'b0011, 4'b1111, 1'b1, 4'b0001};
        tbl[11] = '{4'b0011, 4'b1111, 1'b1, 4'b0010};
        tbl[12] = '{4'b0000, 4'b1111, 1'b1, 4'b0000};
        tbl[13] = '{4'b1101, 4'b1111, 1'b1, 4'b0100};
        tbl[14] = '{4'b0000, 4'b1111, 1'b1, 4'b0000};

        for (int k = 0; k < 4; k++) cnt[k] = 8'd1;
        mv      = 1'b0;
        rst_n   = 1'b0;
        s_valid = 4'b1111;
        s_last  = 4'b0000;
        s_data  = '0;
        m_ready = 1'b1;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_s_ready", 32'(s_ready), 32'(0));
        chk("rst_m_valid", 32'(m_valid), 32'(0));
        chk("rst_m_data", m_data, 32'(0));
        chk("rst_m_id", 32'(m_id), 32'(0));
        chk("rst_m_last", 32'(m_last), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
        s_valid = 4'b0000;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        for (int i = 0; i < 15; i++) begin
            do_cycle(tbl[i].sv, tbl[i].sl, tbl[i].mr, tbl[i].rdy);
        end

        // Requester 1: three-beat burst; requester 2 valid throughout
`ifdef STREAM_ARB_LOCK_EN
        do_cycle(4'b0110, 4'b0100, 1'b1, 4'b0010);
        do_cycle(4'b0110, 4'b0100, 1'b1, 4'b0010);
        do_cycle(4'b0110, 4'b0110, 1'b1, 4'b0010);
        do_cycle(4'b0100, 4'b0100, 1'b1, 4'b0100);
        do_cycle(4'b0100, 4'b0000, 1'b1, 4'b0100);
        do_cycle(4'b1011, 4'b1011, 1'b1, 4'b0000);
        do_cycle(4'b1111, 4'b0000, 1'b1, 4'b0100);
`else
        do_cycle(4'b0110, 4'b0100, 1'b1, 4'b0010);
        do_cycle(4'b0110, 4'b0100, 1'b1, 4'b0100);
        do_cycle(4'b0110, 4'b0100, 1'b1, 4'b0010);
        do_cycle(4'b0110, 4'b0100, 1'b1, 4'b0100);
        do_cycle(4'b0110, 4'b0110, 1'b1, 4'b0010);
        do_cycle(4'b0100, 4'b0000, 1'b1, 4'b0100);
        do_cycle(4'b1011, 4'b1011, 1'b1, 4'b1000);
        do_cycle(4'b1111, 4'b0000, 1'b1, 4'b0001);
`endif

        // Asynchronous reset while a beat is pending
        chk("pre_rst_busy", 32'(busy), 32'(1));
        chk("pre_rst_m_valid", 32'(m_valid), 32'(1));
        rst_n = 1'b0;
        #1;
        chk("async_m_valid", 32'(m_valid), 32'(0));
        chk("async_busy", 32'(busy), 32'(0));
        chk("async_s_ready", 32'(s_ready), 32'(0));
        chk("async_m_data", m_data, 32'(0));
        chk("async_m_id", 32'(m_id), 32'(0));
        sbq.delete();
        mv = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Fairness after reset: 0,1,2,3,0,1 back to back
        do_cycle(4'b1111, 4'b1111, 1'b1, 4'b0001);
        do_cycle(4'b1111, 4'b1111, 1'b1, 4'b0010);
        do_cycle(4'b1111, 4'b1111, 1'b1, 4'b0100);
        do_cycle(4'b1111, 4'b1111, 1'b1, 4'b1000);
        do_cycle(4'b1111, 4'b1111, 1'b1, 4'b0001);
        do_cycle(4'b1111, 4'b1111, 1'b1, 4'b0010);
        do_cycle(4'b0000, 4'b0000, 1'b1, 4'b0000);
        do_cycle(4'b0000, 4'b0000, 1'b1, 4'b0000);

        chk("scoreboard_drained", 32'(sbq.size()), 32'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_rr_arbiter.md
# stream_rr_arbiter

Round-robin arbiter that shares one 32-bit valid/ready stream among NUM_REQ requesters. It forwards the winning beat through a single output register stage, so the forward path is cut. It sits in front of a register slice or downstream consumer wherever several producers contend for one channel. Source ID and end-of-burst are carried alongside the data.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; legal range 2..16.
- IDX_W, 2: width of m_id; must equal ceil(log2(NUM_REQ)).
- DATA_W, 32: beat width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- s_valid  input  NUM_REQ  per-requester beat valid; once asserted, held until accepted.
- s_ready  output  NUM_REQ  per-requester accept; combinational; at most one bit high (one-hot or zero).
- s_data  input  NUM_REQ*DATA_W  requester k data in bits [k*DATA_W +: DATA_W].
- s_last  input  NUM_REQ  per-requester end-of-burst marker.
- m_valid  output  1  registered output beat valid.
- m_ready  input  1  downstream accept.
- m_data  output  DATA_W  registered beat data.
- m_id  output  IDX_W  index of the requester that sourced m_data.
- m_last  output  1  registered copy of the winning s_last.
- busy  output  1  high when m_valid is high or the arbiter is locked.

## Operation
- Slot free: slot_free = !m_valid || m_ready.
- Winner: the first index w, searching ptr, ptr+1, …, wrapping modulo NUM_REQ, with s_valid[w] = 1.
  - Computed only in state ARB.
  - In state LOCK, w = lock_id.
- s_ready[w] = slot_free && s_valid[w] for the winner only; all other bits are 0.
- Accept: s_valid[w] && s_ready[w]. On accept, on the next edge:
  - m_valid <= 1.
  - m_data <= s_data[w], m_id <= w, m_last <= s_last[w].
  - ptr <= (w+1) mod NUM_REQ.
- Output handshake:
  - m_ready && m_valid with no new accept -> m_valid <= 0.
  - m_data, m_id and m_last hold until the next accept.
- Simultaneous drain and accept: the output register is overwritten in the same edge; m_valid stays 1 with no bubble.
- Pointer:
  - ptr advances only on accept.
  - Requesters that are idle never hold priority.
  - ptr wraps from NUM_REQ-1 to 0.
- State machine (two states: ARB and LOCK):
  - ARB -> LOCK: on accept with s_last[w] = 0, only when STREAM_ARB_LOCK_EN is defined. Set lock_id <= w.
  - LOCK -> ARB: on accept with s_last = 1 from lock_id.
  - In LOCK, other requesters are never granted, even while lock_id is idle.
  - Without the macro, the FSM stays in ARB permanently.
- Reset values:
  - m_valid = 0, m_data = 0, m_id = 0, m_last = 0, busy = 0.
  - ptr = 0, state ARB, lock_id = 0.
  - s_ready = 0 while rst_n is low.
- Reset mid-operation: the pending output beat is discarded and the lock is released. The requester must re-present any beat not yet accepted.

## Timing
- Latency: one cycle from accept at input to m_valid at output.
- Throughput: one beat per cycle while m_ready stays high, including back-to-back beats from different requesters.
- Combinational paths:
  - s_ready depends combinationally on m_ready, s_valid, ptr and state.
  - No combinational path from s_* to m_*.
- Backpressure: m_valid=1 with m_ready=0 -> all s_ready=0. The output register holds its value stable.
- Fairness: with all NUM_REQ requesters continuously valid and unlocked, grants rotate 0,1,…,NUM_REQ-1, 0, …. Each requester waits at most NUM_REQ-1 beats.

## Configuration
- STREAM_ARB_LOCK_EN defined:
  - Burst lock is active; the grant is held from the first beat to the s_last beat of a burst.
  - Bursts from different requesters never interleave on m_*.
- STREAM_ARB_LOCK_EN undefined:
  - Arbitration happens on every beat, and the LOCK state and lock_id are not synthesized.
  - s_last is still forwarded to m_last but does not affect grants.

## Test plan
- Reset, then s_valid=4'b0001, s_data[0]=32'hA5A5_0001, m_ready=1 -> s_ready=4'b0001 in the same cycle. Next cycle: m_valid=1, m_data=32'hA5A5_0001, m_id=0.
- All four requesters valid continuously, m_ready=1, unlocked -> m_id sequence 0,1,2,3,0,1 with one beat per cycle and no bubbles.
- m_ready=0 for 3 cycles with m_valid=1 -> s_ready=0 and m_data unchanged across those cycles. Releasing m_ready -> the next beat appears the following cycle.
- ptr=2, s_valid=4'b0011 -> requester 0 granted (wrap), then requester 1; ptr ends at 2.
- With STREAM_ARB_LOCK_EN: requester 1 sends 3 beats with s_last on beat 3 while requester 2 is valid throughout -> m_id=1,1,1, then 2. Without the macro -> m_id=1,2,1,2,1.
- rst_n pulsed low while m_valid=1 and LOCK is active -> m_valid=0 and busy=0 immediately (asynchronous). After release, ptr=0 and requester 0 wins first.
